// File: rtl/vector_pkg.sv
// Shared widths, mode codes and entry layouts for the vector front-end sequencer.
package vector_pkg;

   localparam int SIZE  = 32;
   localparam int MOD_W = 2;

   localparam logic [MOD_W-1:0] MOD_0 = 2'd0;
   localparam logic [MOD_W-1:0] MOD_1 = 2'd1;
   localparam logic [MOD_W-1:0] MOD_2 = 2'd2;
   localparam logic [MOD_W-1:0] MOD_3 = 2'd3;

   typedef struct packed {
      logic [SIZE-1:0]  a;
      logic [SIZE-1:0]  b;
      logic [MOD_W-1:0] mod;
   } op_entry_t;

   typedef struct packed {
      logic [SIZE-1:0]  data;
      logic [MOD_W-1:0] mod;
   } res_entry_t;

endpackage

// File: rtl/vector_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; any DEPTH >= 1, reads zero while empty.
module vector_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_idx, rd_idx;
   logic             wr_wrap, rd_wrap;
   logic             do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
   assign full    = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
   assign rd_data = empty ? '0 : mem[rd_idx];

   // NOTE: every path assigns count, so no latch is inferred.
   always_comb begin
      if (wr_wrap == rd_wrap)
         count = CW'(int'(wr_idx) - int'(rd_idx));
      else
         count = CW'(DEPTH + int'(wr_idx) - int'(rd_idx));
   end

   function automatic logic last_slot(input logic [AW-1:0] idx);
      return idx == AW'(DEPTH - 1);
   endfunction

   // NOTE: state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx  <= '0;
         rd_idx  <= '0;
         wr_wrap <= 1'b0;
         rd_wrap <= 1'b0;
      end else begin
         if (do_push) begin
            wr_idx  <= last_slot(wr_idx) ? '0 : wr_idx + AW'(1);
            wr_wrap <= wr_wrap ^ last_slot(wr_idx);
         end
         if (do_pop) begin
            rd_idx  <= last_slot(rd_idx) ? '0 : rd_idx + AW'(1);
            rd_wrap <= rd_wrap ^ last_slot(rd_idx);
         end
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_idx] <= wr_data;
   end

endmodule

// File: rtl/vector_issue.sv
// Credit-based issue sequencer in front of a fixed-latency vector unit.
module vector_issue
   import vector_pkg::*;
#(
   parameter int SIZE      = vector_pkg::SIZE,
   parameter int VEC_LAT   = 2,
   parameter int OP_DEPTH  = 4,
   parameter int RES_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SIZE-1:0]  in_a,
   input  logic [SIZE-1:0]  in_b,
   input  logic [1:0]       in_mod,
   output logic [SIZE-1:0]  vec_a,
   output logic [SIZE-1:0]  vec_b,
   output logic [1:0]       vec_mod,
   input  logic [SIZE-1:0]  vec_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SIZE-1:0]  res_data,
   output logic [1:0]       res_mod,
   output logic             busy
);

   localparam int OP_W  = 2 * SIZE + MOD_W;
   localparam int RES_W = SIZE + MOD_W;
   localparam int OCW   = $clog2(OP_DEPTH + 1);
   localparam int CW    = $clog2(RES_DEPTH + 1);

   logic [OP_W-1:0]  op_rd;
   logic             op_full, op_empty;
   logic [OCW-1:0]   op_count;
   logic [RES_W-1:0] res_rd;
   logic             res_full, res_empty;
   logic [CW-1:0]    res_count;
   logic             issue, pop, capture;
   logic [CW-1:0]    credit;
   logic [VEC_LAT-1:0] tag_v;
   logic [MOD_W-1:0]   tag_mod [VEC_LAT];

   assign in_ready  = !op_full;
   assign issue     = !op_empty && (credit != '0);
   assign res_valid = !res_empty;
   assign pop       = res_valid && res_ready;
   assign capture   = tag_v[VEC_LAT-1];
   assign {res_data, res_mod} = res_rd;
   assign busy      = !op_empty || (tag_v != '0) || !res_empty;

   vector_sync_fifo #(.WIDTH(OP_W), .DEPTH(OP_DEPTH)) u_op_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (in_valid && in_ready),
      .wr_data ({in_a, in_b, in_mod}),
      .pop     (issue),
      .rd_data (op_rd),
      .full    (op_full),
      .empty   (op_empty),
      .count   (op_count)
   );

   vector_sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (capture),
      .wr_data ({vec_out, tag_mod[VEC_LAT-1]}),
      .pop     (pop),
      .rd_data (res_rd),
      .full    (res_full),
      .empty   (res_empty),
      .count   (res_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_a   <= '0;
         vec_b   <= '0;
         vec_mod <= '0;
      end else if (issue) begin
         {vec_a, vec_b, vec_mod} <= op_rd;
      end
   end

   // Tag pipe mirrors the vector unit latency; its tail marks the edge vec_out is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         for (int i = 0; i < VEC_LAT; i++) tag_mod[i] <= '0;
      end else begin
         tag_v[0]   <= issue;
         tag_mod[0] <= op_rd[MOD_W-1:0];
         for (int i = 1; i < VEC_LAT; i++) begin
            tag_v[i]   <= tag_v[i-1];
            tag_mod[i] <= tag_mod[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit <= CW'(RES_DEPTH);
      end else begin
         case ({issue, pop})
            2'b10:   credit <= credit - CW'(1);
            2'b01:   credit <= credit + CW'(1);
            default: credit <= credit;
         endcase
      end
   end

   // Every result slot is either a credit, in flight, or occupied.
   a_credit_range: assert property (@(posedge clk) disable iff (!rst_n)
      int'(credit) <= RES_DEPTH);
   a_slot_balance: assert property (@(posedge clk) disable iff (!rst_n)
      int'(credit) + int'(res_count) + $countones(tag_v) == RES_DEPTH);
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(capture && res_full));
   a_op_count: assert property (@(posedge clk) disable iff (!rst_n)
      int'(op_count) <= OP_DEPTH);

endmodule

// File: tb/tb_vector_issue.sv
// Directed bench for vector_issue with a registered XOR stub as the vector unit.
module tb_vector_issue;
   import vector_pkg::*;

   localparam int VEC_LAT   = 2;
   localparam int OP_DEPTH  = 4;
   localparam int RES_DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [SIZE-1:0] in_a = '0;
   logic [SIZE-1:0] in_b = '0;
   logic [1:0]      in_mod = '0;
   logic [SIZE-1:0] vec_a, vec_b;
   logic [1:0]      vec_mod;
   logic [SIZE-1:0] vec_out = '0;
   logic            res_valid;
   logic            res_ready = 1'b1;
   logic [SIZE-1:0] res_data;
   logic [1:0]      res_mod;
   logic            busy;

   int total = 0;
   int bad   = 0;
   int n_acc = 0;
   int n_pop = 0;
   logic run = 1'b0;
   res_entry_t model_q[$];

   always #5 clk = ~clk;

   vector_issue #(.SIZE(SIZE), .VEC_LAT(VEC_LAT), .OP_DEPTH(OP_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mod    (in_mod),
      .vec_a     (vec_a),
      .vec_b     (vec_b),
      .vec_mod   (vec_mod),
      .vec_out   (vec_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_mod   (res_mod),
      .busy      (busy)
   );

   // Single-registered vector unit stub.
   always @(posedge clk) vec_out <= vec_a ^ vec_b;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: every accepted pair owes exactly one result, in order, tagged with its mode.
   always @(posedge clk) begin
      if (rst_n) begin
         if (res_valid && res_ready) begin
            n_pop++;
            if (model_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pop_without_pending: got result %h expected none", res_data);
            end else begin
               void'(model_q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            model_q.push_back('{data: in_a ^ in_b, mod: in_mod});
            n_acc++;
         end
      end
   end

   always @(negedge rst_n) model_q.delete();

   always @(negedge clk) begin
      if (rst_n && run) begin
         check("busy", busy, model_q.size() != 0);
         if (res_valid) begin
            if (model_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL stale_result: got %h expected no result", res_data);
            end else begin
               check("res_data", res_data, model_q[0].data);
               check("res_mod", res_mod, model_q[0].mod);
            end
         end
      end
   end

   function automatic op_entry_t mk(input int idx, input logic [SIZE-1:0] base);
      op_entry_t e;
      e.a   = base + SIZE'(idx);
      e.b   = 32'h5a5a_0000 + SIZE'(idx * 7);
      e.mod = MOD_W'(idx);
      return e;
   endfunction

   task automatic put(input op_entry_t e);
      in_a   = e.a;
      in_b   = e.b;
      in_mod = e.mod;
   endtask

   // Offers ops first..n-1 back to back; leaves in_valid high if the budget runs out.
   task automatic stream(input int first, input int n, input int budget, input logic toggle,
                         input logic [SIZE-1:0] base, output int accepted);
      int b0 = n_acc;
      int idx;
      in_valid = 1'b1;
      put(mk(first, base));
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (toggle) res_ready = ~res_ready;
         idx = first + (n_acc - b0);
         if (idx >= n) begin
            in_valid = 1'b0;
            break;
         end
         put(mk(idx, base));
      end
      accepted = n_acc - b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int c = 0;
      while ((busy || model_q.size() != 0) && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (c >= budget) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, budget);
      end
   endtask

   task automatic wait_valid(input string name, input int budget);
      int c = 0;
      while (!res_valid && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({name, "_valid"}, res_valid, 1'b1);
   endtask

   initial begin
      int acc;
      int p0;
      logic [MOD_W-1:0] mods [4];
      mods = '{MOD_0, MOD_1, MOD_2, MOD_3};

      // Reset state
      #12;
      check("rst_vec_a", vec_a, '0);
      check("rst_vec_b", vec_b, '0);
      check("rst_vec_mod", vec_mod, '0);
      check("rst_res_data", res_data, '0);
      check("rst_res_mod", res_mod, '0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);

      // Single op: latency of three edges after the handshake
      in_valid = 1'b1;
      in_a = 32'h0000ffff;
      in_b = 32'h0abcffff;
      in_mod = MOD_0;
      @(negedge clk);
      in_valid = 1'b0;
      check("t1_lat0", res_valid, 1'b0);
      @(negedge clk);
      check("t1_lat1", res_valid, 1'b0);
      check("t1_issue_vec_a", vec_a, 32'h0000ffff);
      check("t1_issue_vec_b", vec_b, 32'h0abcffff);
      @(negedge clk);
      check("t1_lat2", res_valid, 1'b0);
      @(negedge clk);
      check("t1_lat3", res_valid, 1'b1);
      check("t1_data", res_data, 32'h0abc0000);
      check("t1_mod", res_mod, MOD_0);
      @(negedge clk);
      check("t1_busy_after_pop", busy, 1'b0);
      check("t1_valid_after_pop", res_valid, 1'b0);

      // Four back-to-back ops, one result per cycle
      p0 = n_acc;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_a = 32'h0000ffff;
         in_b = 32'h0abcffff;
         in_mod = mods[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("t2_accepted", n_acc - p0, 4);
      wait_valid("t2", 10);
      for (int i = 0; i < 4; i++) begin
         check("t2_stream_valid", res_valid, 1'b1);
         check("t2_stream_data", res_data, 32'h0abc0000);
         check("t2_stream_mod", res_mod, mods[i]);
         @(negedge clk);
      end
      check("t2_done", res_valid, 1'b0);
      wait_idle("t2", 20);

      // Stalled output: 8 accepted, issue capped by credit, then drain
      res_ready = 1'b0;
      p0 = n_pop;
      stream(0, 10, 20, 1'b0, 32'h0000_1000, acc);
      check("t3_accepted", acc, OP_DEPTH + RES_DEPTH);
      check("t3_in_ready", in_ready, 1'b0);
      check("t3_in_valid_held", in_valid, 1'b1);
      check("t3_hold_vec_a", vec_a, mk(3, 32'h0000_1000).a);
      check("t3_hold_vec_b", vec_b, mk(3, 32'h0000_1000).b);
      check("t3_hold_vec_mod", vec_mod, mk(3, 32'h0000_1000).mod);
      res_ready = 1'b1;
      stream(8, 10, 100, 1'b0, 32'h0000_1000, acc);
      check("t3_rest_accepted", acc, 2);
      wait_idle("t3", 100);
      check("t3_popped", n_pop - p0, 10);

      // Toggling res_ready on a continuous input stream
      p0 = n_pop;
      stream(0, 16, 400, 1'b1, 32'hc0de_0000, acc);
      check("t4_accepted", acc, 16);
      res_ready = 1'b1;
      wait_idle("t4", 100);
      check("t4_popped", n_pop - p0, 16);

      // Reset with work spread across FIFOs and pipe
      res_ready = 1'b0;
      stream(0, 5, 20, 1'b0, 32'h7777_0000, acc);
      check("t5_accepted", acc, 5);
      check("t5_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_vec_a", vec_a, '0);
      check("t5_rst_vec_b", vec_b, '0);
      check("t5_rst_vec_mod", vec_mod, '0);
      check("t5_rst_res_data", res_data, '0);
      check("t5_rst_res_mod", res_mod, '0);
      check("t5_rst_res_valid", res_valid, 1'b0);
      check("t5_rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      res_ready = 1'b1;
      p0 = n_pop;
      in_valid = 1'b1;
      in_a = 32'd1;
      in_b = 32'd3;
      in_mod = MOD_0;
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid("t5", 10);
      check("t5_first_data", res_data, 32'd2);
      check("t5_first_mod", res_mod, MOD_0);
      wait_idle("t5", 20);
      check("t5_popped", n_pop - p0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vector_issue.md
Name: vector_issue

Overview:
- Front-end sequencer for the `vector` unit, driving its `A`, `B` and `mod` inputs and collecting its `out`.
- Accepts operand pairs plus mode over a valid/ready stream and buffers them.
- Issues at most one pair per cycle to the vector unit, and only when a result slot is guaranteed.
- Captures `out` after a fixed latency and returns each result, tagged with its mode, over a valid/ready stream.

Parameters:
- `SIZE`, default 32: operand and result width in bits.
- `VEC_LAT`, default 2: rising edges after the `vec_*` update at which `vec_out` is sampled (1 = combinational unit, 2 = single-registered unit). Must be ≥1.
- `OP_DEPTH`, default 4: operand FIFO entries, power of 2, ≥2.
- `RES_DEPTH`, default 4: result FIFO entries, ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  operand FIFO not full.
- `in_a`  in  SIZE  operand A.
- `in_b`  in  SIZE  operand B.
- `in_mod`  in  2  operation/lane mode for this pair.
- `vec_a`  out  SIZE  drives vector unit `A`.
- `vec_b`  out  SIZE  drives vector unit `B`.
- `vec_mod`  out  2  drives vector unit `mod`.
- `vec_out`  in  SIZE  vector unit `out`.
- `res_valid`  out  1  result FIFO not empty.
- `res_ready`  in  1  downstream accepts result.
- `res_data`  out  SIZE  result word.
- `res_mod`  out  2  mode the result was computed with.
- `busy`  out  1  any entry in operand FIFO, pipeline or result FIFO.

Behaviour:
- Reset (async assert, sync-style release): both FIFOs empty; valid pipeline cleared; credit = RES_DEPTH.
  - Register outputs clear to 0: `vec_a`, `vec_b`, `vec_mod`, `res_data`, `res_mod`.
  - `res_valid` = 0, `busy` = 0. `in_ready` = 1 once reset deasserts.
  - Reset mid-operation discards all queued and in-flight work; no result emerges afterwards.
- Input handshake: a write happens when `in_valid` and `in_ready` are both high. `in_ready` = !op_full (registered occupancy). No same-cycle bypass, so a full FIFO refuses input even when popping that cycle.
- Issue condition: op FIFO non-empty and credit > 0.
  - On issue edge: pop op FIFO; load `vec_a`/`vec_b`/`vec_mod`; push `valid=1` plus mod into a VEC_LAT-deep tag shift register; credit−1.
  - When not issuing, `vec_*` hold their last values and a 0 enters the tag pipe.
- Capture: when the tag pipe tail is 1, `vec_out` and the tag mod are written into the result FIFO on that edge. The credit scheme guarantees space, so it never overflows.
- Output handshake: `res_valid` = !res_empty. A pop happens when `res_valid` and `res_ready` are both high. Each pop adds +1 credit, which is usable from the next cycle.
- Credit update: next = credit − issue + pop. Simultaneous issue and pop leaves credit unchanged. Credit never exceeds RES_DEPTH or drops below 0 (assertion).
- Latency, empty system:
  - Input handshake at edge k, issue at edge k+1, capture at edge k+1+VEC_LAT.
  - `res_valid` is high after edge k+1+VEC_LAT: 3 cycles at the default.
- Throughput: 1 result/cycle when `res_ready` stays high and RES_DEPTH ≥ VEC_LAT+1. Smaller RES_DEPTH throttles issue, never drops data.
- Ordering: strict FIFO order; `res_mod` always matches the mod issued with that pair.
- FIFO pointers: wrap-around at DEPTH; full/empty distinguished by an extra pointer bit.
- `busy` = !op_empty | (tag pipe ≠ 0) | !res_empty.

Decomposition:
- Package `vector_pkg`:
  - `SIZE` default.
  - `MOD_W`=2.
  - Mode constants `MOD_0`..`MOD_3`.
  - Packed struct of operand entry {a, b, mod}.
  - Packed struct of result entry {data, mod}.
- Sub-module `vector_sync_fifo` (WIDTH, DEPTH; push/pop/full/empty/count), instantiated for both the operand and result FIFOs.
- Credit counter and tag pipe stay in `vector_issue`.

Test Plan:
- Bench stub vector unit, VEC_LAT=2: registered `out = A ^ B`.
- Single op, A=32'h0000ffff, B=32'h0abcffff, mod=0 → `res_valid` rises 3 cycles after the handshake with `res_data`=32'h0abc0000, `res_mod`=0; `busy` falls after the pop.
- Four back-to-back ops with the same A/B and mod=0,1,2,3, `res_ready`=1 → four consecutive results, `res_mod`=0,1,2,3, one per cycle, no bubbles.
- `res_ready`=0, push 10 ops → exactly RES_DEPTH+OP_DEPTH=8 accepted, then `in_ready` low.
  - Issue stops after 4 (credit 0); `vec_*` hold their values.
  - Raise `res_ready` → all 8 results return in order, then the remaining 2 are accepted.
- Toggle `res_ready` 1-0-1-0 on a continuous input stream → no loss or duplication; credit stays in 0..4; result sequence matches the input order.
- Assert `rst_n`=0 for one cycle with 2 ops in the pipe and 3 in the FIFOs → all outputs 0 and `busy`=0. The next op, A=1, B=3, yields `res_data`=2 with no stale results before it.
